// File: rtl/preg_free_list.sv
// Circular free list of physical registers for rename: up to two allocations
// and two returns per cycle, with a sticky protocol-error flag.
module preg_free_list #(
    parameter int P_REGISTERS  = 64,
    parameter int L_REGS       = 8,
    parameter int P_ADDR_WIDTH = $clog2(P_REGISTERS),
    parameter int DEPTH        = P_REGISTERS - L_REGS,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pop_1,
    input  logic                    pop_2,
    output logic [P_ADDR_WIDTH-1:0] free_preg_1,
    output logic [P_ADDR_WIDTH-1:0] free_preg_2,
    output logic                    one_free,
    output logic                    two_free,
    output logic [CNT_W-1:0]        free_cnt,
    input  logic                    rel_valid_1,
    input  logic [P_ADDR_WIDTH-1:0] rel_preg_1,
    input  logic                    rel_valid_2,
    input  logic [P_ADDR_WIDTH-1:0] rel_preg_2,
    output logic                    err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = CNT_W + 2;

    logic [P_ADDR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [1:0]       npop, npop_eff, nrel, nrel_eff;
    logic             bad_pop, pop_ok, rel_ok;
    logic [CW-1:0]    cnt_ext, cnt_after_pop, cnt_after_all;
    logic [PTR_W-1:0] head_p1, tail_p1, wr2_idx;
    logic             wr1_en, wr2_en;

    // DEPTH is not a power of two, so wrap is an explicit compare against DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                  input logic [1:0]       n);
        logic [PTR_W:0] s;
        s = (PTR_W+1)'(p) + (PTR_W+1)'(n);
        if (s > (PTR_W+1)'(DEPTH - 1)) begin
            s = s - (PTR_W+1)'(DEPTH);
        end
        return PTR_W'(s);
    endfunction

    always_comb begin
        npop    = {1'b0, pop_1} + {1'b0, pop_2};
        nrel    = {1'b0, rel_valid_1} + {1'b0, rel_valid_2};
        bad_pop = pop_2 & ~pop_1;
        cnt_ext = CW'(cnt_q);

        // Same-cycle releases are never counted as poppable stock.
        pop_ok   = ~bad_pop & ~(CW'(npop) > cnt_ext);
        npop_eff = pop_ok ? npop : 2'd0;

        cnt_after_pop = cnt_ext - CW'(npop_eff);
        cnt_after_all = cnt_after_pop + CW'(nrel);
        rel_ok        = (cnt_after_all <= CW'(DEPTH));
        nrel_eff      = rel_ok ? nrel : 2'd0;

        head_p1 = ptr_add(head_q, 2'd1);
        tail_p1 = ptr_add(tail_q, 2'd1);

        // Port 2 lands at tail when port 1 is idle, otherwise right behind it.
        wr1_en  = rel_ok & rel_valid_1;
        wr2_en  = rel_ok & rel_valid_2;
        wr2_idx = rel_valid_1 ? tail_p1 : tail_q;

        head_d = ptr_add(head_q, npop_eff);
        tail_d = ptr_add(tail_q, nrel_eff);
        cnt_d  = rel_ok ? CNT_W'(cnt_after_all) : CNT_W'(cnt_after_pop);
        err_d  = err_q | ~pop_ok | ~rel_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                mem_q[i] <= P_ADDR_WIDTH'(unsigned'(L_REGS) + i);
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CNT_W'(DEPTH);
            err_q  <= 1'b0;
        end else begin
            if (wr1_en) begin
                mem_q[tail_q] <= rel_preg_1;
            end
            if (wr2_en) begin
                mem_q[wr2_idx] <= rel_preg_2;
            end
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign free_preg_1 = mem_q[head_q];
    assign free_preg_2 = mem_q[head_p1];
    assign one_free    = (cnt_q != '0);
    assign two_free    = (cnt_q >= CNT_W'(2));
    assign free_cnt    = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Randomised and directed checks of preg_free_list against a queue-based model
// of the free list, plus literal expectations for the documented scenarios.
module tb_preg_free_list;

    localparam int DEPTH = 56;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pop_1 = 1'b0, pop_2 = 1'b0;
    logic       rel_valid_1 = 1'b0, rel_valid_2 = 1'b0;
    logic [5:0] rel_preg_1 = '0, rel_preg_2 = '0;
    logic [5:0] free_preg_1, free_preg_2;
    logic       one_free, two_free, err;
    logic [5:0] free_cnt;

    int errors = 0;
    int checks = 0;

    int fl[$];
    bit merr;

    preg_free_list #(.P_REGISTERS(64), .L_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pop_1(pop_1), .pop_2(pop_2),
        .free_preg_1(free_preg_1), .free_preg_2(free_preg_2),
        .one_free(one_free), .two_free(two_free), .free_cnt(free_cnt),
        .rel_valid_1(rel_valid_1), .rel_preg_1(rel_preg_1),
        .rel_valid_2(rel_valid_2), .rel_preg_2(rel_preg_2),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 8; i < 64; i++) fl.push_back(i);
        merr = 1'b0;
    endtask

    // Free list as a plain FIFO: accepted pops leave the front, accepted releases join the back.
    task automatic model_step();
        int np, ne, nr;
        np = int'(pop_1) + int'(pop_2);
        nr = int'(rel_valid_1) + int'(rel_valid_2);
        ne = 0;
        if (pop_2 && !pop_1) merr = 1'b1;
        else if (np > fl.size()) merr = 1'b1;
        else ne = np;
        for (int k = 0; k < ne; k++) void'(fl.pop_front());
        if (fl.size() + nr > DEPTH) merr = 1'b1;
        else begin
            if (rel_valid_1) fl.push_back(int'(rel_preg_1));
            if (rel_valid_2) fl.push_back(int'(rel_preg_2));
        end
    endtask

    always @(posedge clk) if (rst_n) model_step();

    always @(negedge clk) begin
        check("free_cnt", int'(free_cnt), fl.size());
        check("one_free", int'(one_free), int'(fl.size() >= 1));
        check("two_free", int'(two_free), int'(fl.size() >= 2));
        check("err", int'(err), int'(merr));
        if (fl.size() >= 1) check("free_preg_1", int'(free_preg_1), fl[0]);
        if (fl.size() >= 2) check("free_preg_2", int'(free_preg_2), fl[1]);
    end

    task automatic step(input bit p1, input bit p2, input bit v1, input int r1,
                        input bit v2, input int r2);
        pop_1 = p1; pop_2 = p2;
        rel_valid_1 = v1; rel_preg_1 = 6'(r1);
        rel_valid_2 = v2; rel_preg_2 = 6'(r2);
        @(posedge clk);
        #1;
        pop_1 = 0; pop_2 = 0; rel_valid_1 = 0; rel_valid_2 = 0;
    endtask

    task automatic do_reset();
        pop_1 = 0; pop_2 = 0; rel_valid_1 = 0; rel_valid_2 = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_step(input bit legal);
        int sz, np;
        bit p1, p2, v1, v2;
        sz = fl.size();
        np = $urandom_range(0, 2);
        if (legal && np > sz) np = sz;
        p1 = (np >= 1);
        p2 = (np == 2);
        if (!legal && $urandom_range(0, 7) == 0) begin p1 = 0; p2 = 1; end
        v1 = 1'($urandom_range(0, 1));
        v2 = 1'($urandom_range(0, 1));
        if (legal) begin
            while (sz - np + int'(v1) + int'(v2) > DEPTH) begin
                if (v1) v1 = 0; else v2 = 0;
            end
        end
        step(p1, p2, v1, $urandom_range(0, 63), v2, $urandom_range(0, 63));
    endtask

    initial begin
        model_reset();
        do_reset();

        // T1: reset in the middle of traffic with inputs active
        repeat (40) rand_step(1'b1);
        pop_1 = 1; pop_2 = 1; rel_valid_1 = 1; rel_preg_1 = 6'd33;
        rel_valid_2 = 1; rel_preg_2 = 6'd34;
        #3 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        pop_1 = 0; pop_2 = 0; rel_valid_1 = 0; rel_valid_2 = 0;
        rst_n = 1'b1;
        check("t1_fp1", int'(free_preg_1), 8);
        check("t1_fp2", int'(free_preg_2), 9);
        check("t1_cnt", int'(free_cnt), 56);
        check("t1_two_free", int'(two_free), 1);
        check("t1_err", int'(err), 0);

        // T2: drain in pairs
        for (int k = 0; k < 28; k++) begin
            check("t2_fp1", int'(free_preg_1), 8 + 2 * k);
            check("t2_fp2", int'(free_preg_2), 9 + 2 * k);
            step(1, 1, 0, 0, 0, 0);
        end
        check("t2_cnt", int'(free_cnt), 0);
        check("t2_one_free", int'(one_free), 0);
        check("t2_err", int'(err), 0);

        // T3: refill after wrap, port-2-only release
        step(0, 0, 1, 20, 1, 21);
        step(0, 0, 0, 0, 1, 5);
        check("t3_fp1", int'(free_preg_1), 20);
        check("t3_fp2", int'(free_preg_2), 21);
        check("t3_cnt", int'(free_cnt), 3);

        // T4: simultaneous pop of both and release of two
        step(1, 0, 0, 0, 0, 0);
        check("t4_cnt_pre", int'(free_cnt), 2);
        step(1, 1, 1, 40, 1, 41);
        check("t4_cnt", int'(free_cnt), 2);
        check("t4_fp1", int'(free_preg_1), 40);
        check("t4_fp2", int'(free_preg_2), 41);

        // T5a: underflow at cnt=1
        step(1, 0, 0, 0, 0, 0);
        check("t5a_cnt_pre", int'(free_cnt), 1);
        step(1, 1, 0, 0, 0, 0);
        check("t5a_err", int'(err), 1);
        check("t5a_cnt", int'(free_cnt), 1);
        check("t5a_fp1", int'(free_preg_1), 41);

        // Wrap traffic with legal random pops/releases
        do_reset();
        repeat (400) rand_step(1'b1);

        // T5b: pop_2 without pop_1 at cnt=10
        do_reset();
        repeat (23) step(1, 1, 0, 0, 0, 0);
        check("t5b_cnt_pre", int'(free_cnt), 10);
        step(0, 1, 0, 0, 0, 0);
        check("t5b_err", int'(err), 1);
        check("t5b_cnt", int'(free_cnt), 10);
        check("t5b_fp1", int'(free_preg_1), 54);

        // T6: overflow at full, tail must not move
        do_reset();
        step(0, 0, 1, 12, 0, 0);
        check("t6_err", int'(err), 1);
        check("t6_cnt", int'(free_cnt), 56);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 30, 1, 31);
        check("t6_cnt_refill", int'(free_cnt), 56);
        repeat (27) step(1, 1, 0, 0, 0, 0);
        check("t6_tail_fp1", int'(free_preg_1), 30);
        check("t6_tail_fp2", int'(free_preg_2), 31);

        // Random traffic including illegal pops and overflows
        do_reset();
        repeat (300) rand_step(1'b0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
